// File: rtl/go_pkg.sv
// Shared types and constants for the Go player-input cursor controller.
package go_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_BLACK = 2'b01,
    CELL_WHITE = 2'b10
  } cell_e;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_RECENTER,
    ST_WAITING,
    ST_SEEK,
    ST_ISSUE
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  // Bit positions of the buttons in the edge-detect vector.
  localparam int BTN_W     = 6;
  localparam int BTN_PASS  = 5;
  localparam int BTN_MAKE  = 4;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  // Pass is signalled as an all-ones coordinate; consumers slice to their width.
  localparam logic [63:0] PASS_CODE = '1;

  function automatic int centre(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/go_edge_detect.sv
// Rising-edge detector for a vector of debounced button levels.
module go_edge_detect #(
  parameter int W = 1
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] level_q;

  // Registered copy of the levels; a rise is current-high with previous-low.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) level_q <= '0;
    else          level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/go_cursor_ctrl.sv
// Player input block: cursor movement over the board and move issue handshake.
//
// state    | meaning
// ---------+------------------------------------------------------------
// LOCKED   | not our turn; waits for my_turn
// RECENTER | one cycle, cursor returns to the board centre
// WAITING  | accepts button edges (pass > make > up > down > left > right)
// SEEK     | steps a candidate one cell per cycle in the latched direction
// ISSUE    | move offered on move_valid until move_ready
module go_cursor_ctrl
  import go_pkg::*;
#(
  parameter int BOARD_N       = 9,
  parameter int COORD_W       = 5,
  parameter int SKIP_OCCUPIED = 1,
  parameter int WRAP          = 1
) (
  input  logic                                  clk_in,
  input  logic                                  reset_n,
  input  logic                                  my_turn,
  input  logic                                  pass_sw,
  input  logic                                  up,
  input  logic                                  down,
  input  logic                                  left,
  input  logic                                  right,
  input  logic                                  make_move,
  input  logic [BOARD_N-1:0][BOARD_N-1:0][1:0]  board,
  input  logic                                  move_ready,
  output logic                                  locked,
  output logic [2*COORD_W-1:0]                  cursor_pos,
  output logic                                  move_valid,
  output logic                                  move_pass,
  output logic [2*COORD_W-1:0]                  move_out,
  output logic                                  illegal
);

  localparam int                 IDX_W     = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
  localparam logic [COORD_W-1:0] CENTRE    = COORD_W'(centre(BOARD_N));
  localparam logic [COORD_W-1:0] LAST      = COORD_W'(BOARD_N - 1);
  localparam logic [COORD_W-1:0] STEP_LAST = COORD_W'(BOARD_N - 2);
  localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);
  localparam logic [COORD_W:0]   ONE_EXT   = (COORD_W+1)'(1);
  localparam logic [COORD_W:0]   N_EXT     = (COORD_W+1)'(BOARD_N);

  state_e               state_q, state_d;
  dir_e                 dir_q, dir_d;
  logic [COORD_W-1:0]   cur_row_q, cur_col_q, cur_row_d, cur_col_d;
  logic [COORD_W-1:0]   cand_row_q, cand_col_q, cand_row_d, cand_col_d;
  logic [COORD_W-1:0]   step_cnt_q, step_cnt_d;
  logic                 move_valid_d, move_pass_d, illegal_d;
  logic [2*COORD_W-1:0] move_out_d;
  logic [BTN_W-1:0]     btn_lvl, btn_rise;

  logic                 vertical, incr, at_edge;
  logic [COORD_W-1:0]   axis, axis_next, nxt_row, nxt_col;
  logic [COORD_W:0]     axis_ext;
  logic                 cur_empty, nxt_empty;

  assign btn_lvl = {pass_sw, make_move, up, down, left, right};

  go_edge_detect #(.W(BTN_W)) u_edge (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .level   (btn_lvl),
    .rise    (btn_rise)
  );

  // One-cell step of the candidate; the extra bit exposes 0-1 and N-1+1 before wrapping.
  always_comb begin
    vertical = (dir_q == DIR_UP) || (dir_q == DIR_DOWN);
    incr     = (dir_q == DIR_UP) || (dir_q == DIR_LEFT);
    axis     = vertical ? cand_row_q : cand_col_q;
    axis_ext = incr ? ({1'b0, axis} + ONE_EXT) : ({1'b0, axis} - ONE_EXT);
    at_edge  = incr ? (axis_ext == N_EXT) : axis_ext[COORD_W];
    if (at_edge) axis_next = incr ? '0 : LAST;
    else         axis_next = axis_ext[COORD_W-1:0];
    nxt_row  = vertical ? axis_next : cand_row_q;
    nxt_col  = vertical ? cand_col_q : axis_next;
  end

  assign cur_empty = (board[cur_row_q[IDX_W-1:0]][cur_col_q[IDX_W-1:0]] == CELL_EMPTY);
  assign nxt_empty = (board[nxt_row[IDX_W-1:0]][nxt_col[IDX_W-1:0]] == CELL_EMPTY);

  // Next-state and registered-output logic; losing the turn overrides everything.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    cand_row_d   = cand_row_q;
    cand_col_d   = cand_col_q;
    step_cnt_d   = step_cnt_q;
    move_valid_d = move_valid;
    move_pass_d  = move_pass;
    move_out_d   = move_out;
    illegal_d    = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        if (my_turn) state_d = ST_RECENTER;
      end
      ST_RECENTER: begin
        cur_row_d = CENTRE;
        cur_col_d = CENTRE;
        state_d   = ST_WAITING;
      end
      ST_WAITING: begin
        if (btn_rise[BTN_PASS]) begin
          state_d      = ST_ISSUE;
          move_valid_d = 1'b1;
          move_pass_d  = 1'b1;
          move_out_d   = PASS_CODE[2*COORD_W-1:0];
        end else if (btn_rise[BTN_MAKE]) begin
          if (cur_empty) begin
            state_d      = ST_ISSUE;
            move_valid_d = 1'b1;
            move_pass_d  = 1'b0;
            move_out_d   = {cur_row_q, cur_col_q};
          end else begin
            illegal_d = 1'b1;
          end
        end else if (|btn_rise[BTN_UP:BTN_RIGHT]) begin
          state_d    = ST_SEEK;
          cand_row_d = cur_row_q;
          cand_col_d = cur_col_q;
          step_cnt_d = '0;
          if (btn_rise[BTN_UP])        dir_d = DIR_UP;
          else if (btn_rise[BTN_DOWN]) dir_d = DIR_DOWN;
          else if (btn_rise[BTN_LEFT]) dir_d = DIR_LEFT;
          else                         dir_d = DIR_RIGHT;
        end
      end
      ST_SEEK: begin
        if (at_edge && (WRAP == 0)) begin
          state_d = ST_WAITING;
        end else if ((SKIP_OCCUPIED == 0) || nxt_empty) begin
          cur_row_d = nxt_row;
          cur_col_d = nxt_col;
          state_d   = ST_WAITING;
        end else if (step_cnt_q == STEP_LAST) begin
          state_d = ST_WAITING;
        end else begin
          cand_row_d = nxt_row;
          cand_col_d = nxt_col;
          step_cnt_d = step_cnt_q + ONE;
        end
      end
      ST_ISSUE: begin
        if (move_ready) begin
          move_valid_d = 1'b0;
          state_d      = ST_LOCKED;
        end
      end
      default: state_d = ST_LOCKED;
    endcase

    if (!my_turn) begin
      state_d      = ST_LOCKED;
      move_valid_d = 1'b0;
      illegal_d    = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_LOCKED;
      dir_q      <= DIR_UP;
      cur_row_q  <= CENTRE;
      cur_col_q  <= CENTRE;
      cand_row_q <= CENTRE;
      cand_col_q <= CENTRE;
      step_cnt_q <= '0;
      move_valid <= 1'b0;
      move_pass  <= 1'b0;
      move_out   <= '0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      step_cnt_q <= step_cnt_d;
      move_valid <= move_valid_d;
      move_pass  <= move_pass_d;
      move_out   <= move_out_d;
      illegal    <= illegal_d;
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign cursor_pos = {cur_row_q, cur_col_q};

endmodule
